// File: rtl/lsu_stall_unit_pkg.sv
// Shared definitions for the MW-stage load/store unit: funct3 encodings,
// FSM state type and the funct3 access-size decode.
package lsu_stall_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

    typedef struct packed {
        logic is_byte;
        logic is_half;
        logic is_unsigned;
    } struc_inst;

    // Anything that is neither byte nor halfword (010/011/110/111) is a word access
    function automatic struc_inst decode_funct3(input logic [2:0] f3);
        struc_inst d;
        d.is_byte     = (f3[1:0] == 2'b00);
        d.is_half     = (f3[1:0] == 2'b01);
        d.is_unsigned = f3[2];
        return d;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data replication,
// load byte/half extraction with sign or zero extension, and misalign check.
module lsu_align
    import lsu_stall_unit_pkg::*;
#(
    parameter int Width   = 32,
    parameter int AddrLsb = 2
) (
    input  logic [2:0]         funct3,
    input  logic [AddrLsb-1:0] addr_lo,
    input  logic [Width-1:0]   wdata,
    input  logic [2:0]         ld_funct3,
    input  logic [AddrLsb-1:0] ld_addr_lo,
    input  logic [Width-1:0]   bus_rdata,
    output logic [Width/8-1:0] be,
    output logic [Width-1:0]   wdata_lane,
    output logic [Width-1:0]   rdata_ext,
    output logic               misaligned
);

    localparam int Lanes = Width / 8;

    struc_inst            st_dec;
    struc_inst            ld_dec;
    logic [Width-1:0]     shifted;
    logic                 unused_st_unsigned;

    assign st_dec             = decode_funct3(funct3);
    assign ld_dec             = decode_funct3(ld_funct3);
    assign unused_st_unsigned = st_dec.is_unsigned;

    always_comb begin
        be         = {Lanes{1'b1}};
        wdata_lane = wdata;
        misaligned = |addr_lo;
        if (st_dec.is_byte) begin
            be         = {{(Lanes-1){1'b0}}, 1'b1} << addr_lo;
            wdata_lane = {Lanes{wdata[7:0]}};
            misaligned = 1'b0;
        end else if (st_dec.is_half) begin
            be         = {{(Lanes-2){1'b0}}, 2'b11} << addr_lo;
            wdata_lane = {(Width/16){wdata[15:0]}};
            misaligned = addr_lo[0];
        end
    end

    // Word loads are aligned, so the shifted value equals the raw bus word
    assign shifted = bus_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        if (ld_dec.is_byte) begin
            rdata_ext = {{(Width-8){~ld_dec.is_unsigned & shifted[7]}}, shifted[7:0]};
        end else if (ld_dec.is_half) begin
            rdata_ext = {{(Width-16){~ld_dec.is_unsigned & shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/lsu_stall_unit.sv
// MW-stage load/store unit: request/grant/response bus FSM that holds the
// pipeline via stall_MW until the access retires in the DONE cycle.
module lsu_stall_unit
    import lsu_stall_unit_pkg::*;
#(
    parameter int Width   = 32,
    parameter int AddrLsb = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [2:0]         funct3,
    input  logic [Width-1:0]   addr,
    input  logic [Width-1:0]   wdata,
    output logic [Width-1:0]   rdata,
    output logic               stall_MW,
    output logic               misalign,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [Width/8-1:0] dbus_be,
    output logic [Width-1:0]   dbus_addr,
    output logic [Width-1:0]   dbus_wdata,
    input  logic               dbus_gnt,
    input  logic               dbus_rvalid,
    input  logic [Width-1:0]   dbus_rdata
);

    lsu_state_e           state;
    logic [2:0]           ld_funct3;
    logic [AddrLsb-1:0]   ld_addr_lo;
    logic [Width/8-1:0]   be_next;
    logic [Width-1:0]     wdata_next;
    logic [Width-1:0]     rdata_next;
    logic                 misaligned;
    logic                 access;

    assign access = mem_rd | mem_wr;

    lsu_align #(
        .Width   (Width),
        .AddrLsb (AddrLsb)
    ) u_align (
        .funct3     (funct3),
        .addr_lo    (addr[AddrLsb-1:0]),
        .wdata      (wdata),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .bus_rdata  (dbus_rdata),
        .be         (be_next),
        .wdata_lane (wdata_next),
        .rdata_ext  (rdata_next),
        .misaligned (misaligned)
    );

    // Gated by rst so the pipeline sees no stall or trap while reset is held
    always_comb begin
        stall_MW = 1'b0;
        misalign = 1'b0;
        if (!rst) begin
            stall_MW = ((state == IDLE) && access && !misaligned) ||
                       (state == REQ) || (state == WAIT);
            misalign = (state == IDLE) && access && misaligned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_be    <= '0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            rdata      <= '0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        state      <= REQ;
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_wr;
                        dbus_be    <= be_next;
                        dbus_addr  <= {addr[Width-1:AddrLsb], {AddrLsb{1'b0}}};
                        dbus_wdata <= wdata_next;
                        ld_funct3  <= funct3;
                        ld_addr_lo <= addr[AddrLsb-1:0];
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        state    <= WAIT;
                        dbus_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dbus_rvalid) begin
                        if (!dbus_we) begin
                            rdata <= rdata_next;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_stall_unit.md
Name: lsu_stall_unit

Overview:
Load/store unit for the MW stage of the 3-stage pipeline. It drives a request/grant/response data-bus handshake and aligns store data into byte lanes. It sign- or zero-extends load data. It generates stall_MW, which holds the pipeline while a memory access is outstanding, and forwarding logic consumes the captured load result.

Parameters:
Width, 32, data and address width
AddrLsb, 2, log2 of bytes per bus word; word address is addr[Width-1:AddrLsb]

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-high
mem_rd  input  1  MW-stage instruction is a load
mem_wr  input  1  MW-stage instruction is a store
funct3  input  3  RV32I width/sign field of the MW instruction
addr  input  Width  effective address from ALU
wdata  input  Width  store data (rs2 value)
rdata  output  Width  extended load result, valid in DONE cycle
stall_MW  output  1  hold FD/MW pipeline registers
misalign  output  1  one-cycle pulse on misaligned access; no bus traffic
dbus_req  output  1  bus request, registered
dbus_we  output  1  1 = write
dbus_be  output  4  byte enables
dbus_addr  output  Width  word-aligned address (low AddrLsb bits zero)
dbus_wdata  output  Width  lane-aligned store data
dbus_gnt  input  1  request accepted this cycle
dbus_rvalid  input  1  response/ack; earliest one cycle after gnt
dbus_rdata  input  Width  read data, valid with rvalid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset forces state IDLE and clears dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata and rdata to 0. stall_MW and misalign are 0 during reset.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, no access: no transition; stall_MW=0.
- IDLE, (mem_rd|mem_wr) and aligned:
  - stall_MW=1 combinationally.
  - Capture addr, funct3, we=mem_wr, aligned be/wdata.
  - Next state REQ with dbus_req=1.
- IDLE, misaligned: misalign=1 for the cycle, stall_MW=0, no request, stay IDLE.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - funct3 values 011/110/111 are handled as word.
- If mem_rd and mem_wr are both high, mem_wr takes priority.
- REQ: dbus_req, dbus_addr, dbus_we, dbus_be and dbus_wdata are held stable until dbus_gnt. On gnt, dbus_req drops next cycle and the state goes to WAIT. stall_MW=1.
- WAIT: stall_MW=1. On dbus_rvalid, the extended dbus_rdata is registered into rdata (loads only; stores leave rdata unchanged) and the state goes to DONE. rvalid in any other state is ignored.
- DONE: stall_MW=0 for exactly one cycle so the MW instruction retires. rdata is valid. The next state is IDLE. A new access is not accepted in the DONE cycle.
- Minimum latency: request seen in cycle 0, gnt in cycle 1, rvalid in cycle 2, DONE in cycle 3. stall_MW is high for cycles 0-2.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata byte replicated ×4.
  - SH: be=0011<<addr[1:0], halfword replicated ×2.
  - SW: be=1111.
- Load extract: byte/half selected by addr[1:0]. Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Reset mid-operation returns to IDLE and drops dbus_req immediately. Any late rvalid is then ignored.

Decomposition:
- DEFS.svh (shared package) gains:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - A lsu_state_e enum {IDLE, REQ, WAIT, DONE}.
  - Reuse of struc_inst for funct3 decode.
- Sub-module lsu_align (combinational) covers store lane shift, byte-enable generation, load extract/extend and the misalign check. The FSM stays in lsu_stall_unit.

Test Plan:
- LW addr=0x100, gnt at cycle 1, rvalid at cycle 2 with rdata=0xDEADBEEF -> stall_MW high cycles 0-2; DONE at cycle 3 with rdata=0xDEADBEEF; dbus_addr=0x100, be=1111, we=0.
- LB addr=0x103, bus rdata=0x80FF_FF7F -> rdata=0xFFFF_FF80. The same access as LBU -> rdata=0x0000_0080.
- SH addr=0x202, wdata=0x1234_ABCD -> dbus_addr=0x200, be=1100, dbus_wdata=0xABCD_ABCD, we=1. rdata unchanged after ack.
- LW addr=0x101 -> misalign pulses one cycle, dbus_req never asserts, stall_MW=0.
- gnt withheld 5 cycles -> dbus_req and all dbus_* outputs stable throughout; stall_MW high until DONE.
- rst asserted in WAIT -> dbus_req=0 and stall_MW=0 asynchronously; a following rvalid=1 has no effect; the next LW completes normally.
